// File: rtl/axil_times_table_reader.sv
`default_nettype none
// ============================================================================
//  Module      : axil_times_table_reader
//  Description : AXI4-Lite read master that looks up a*b in a memory-mapped
//                times table. A request latches the operands, one AR/R read
//                of word BASE_ADDR + ({a,b} << 2) is issued, and the product
//                is returned with a one-cycle valid pulse and an error flag
//                (SLVERR/DECERR response or response timeout).
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    A_W       operand a width
//    B_W       operand b width
//    RES_W     result width, equal to A_W+B_W
//    ADDR_W    AXI address width
//    DATA_W    AXI read-data width, at least RES_W
//    BASE_ADDR table base byte address (word aligned)
//    TIMEOUT   maximum cycles spent waiting for RVALID after the AR handshake
//  Ports
//    clk          system clock, rising edge
//    rst          asynchronous active-low reset
//    a, b         operands, sampled when read & read_ready
//    read         lookup request
//    read_ready   high only while idle
//    result       product, held until the next lookup completes
//    result_valid one-cycle pulse when result/result_err update
//    result_err   1 = error response or timeout on that lookup
//    araddr/arvalid/arready            AXI4-Lite read address channel
//    rdata/rresp/rvalid/rready         AXI4-Lite read data channel
// ============================================================================
module axil_times_table_reader #(
    parameter int                A_W       = 3,
    parameter int                B_W       = 3,
    parameter int                RES_W     = 6,
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [A_W-1:0]    a,
    input  logic [B_W-1:0]    b,
    input  logic              read,
    output logic              read_ready,
    output logic [RES_W-1:0]  result,
    output logic              result_valid,
    output logic              result_err,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready
);

    // Counter holds 0..TIMEOUT-1 while in DATA; sized with headroom.
    localparam int                 c_CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [1:0]         c_RESP_OK  = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_DATA  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_read_ready;
    logic [RES_W-1:0]   r_result;
    logic               r_result_valid;
    logic               r_result_err;
    logic [ADDR_W-1:0]  r_araddr;
    logic               r_arvalid;
    logic               r_rready;

    // Word address of table entry {a,b}; the sum wraps modulo 2^ADDR_W.
    logic [ADDR_W-1:0]  w_lookup_addr;
    assign w_lookup_addr = BASE_ADDR + (ADDR_W'({a, b}) << 2);

    // Table entries only carry RES_W meaningful bits; the rest of the
    // beat is deliberately dropped.
    generate
        if (DATA_W > RES_W) begin : g_rdata_upper
            logic w_rdata_unused;
            assign w_rdata_unused = ^rdata[DATA_W-1:RES_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_read_ready   <= 1'b1;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_result_err   <= 1'b0;
            r_araddr       <= '0;
            r_arvalid      <= 1'b0;
            r_rready       <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (read) begin
                        r_araddr     <= w_lookup_addr;
                        r_arvalid    <= 1'b1;
                        r_read_ready <= 1'b0;
                        r_state      <= S_ADDR;
                    end
                end

                S_ADDR: begin
                    // araddr/arvalid are only touched here on the handshake,
                    // so they stay stable under backpressure.
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_DATA;
                    end
                end

                S_DATA: begin
                    // A beat arriving in the last allowed cycle still wins
                    // over the timeout.
                    if (rvalid) begin
                        r_rready       <= 1'b0;
                        r_result_valid <= 1'b1;
                        r_read_ready   <= 1'b1;
                        r_state        <= S_IDLE;
                        if (rresp == c_RESP_OK) begin
                            r_result     <= rdata[RES_W-1:0];
                            r_result_err <= 1'b0;
                        end else begin
                            r_result     <= '0;
                            r_result_err <= 1'b1;
                        end
                    end else if (r_cnt == c_CNT_LAST) begin
                        // Report the failure now, but keep rready high so the
                        // late beat is consumed before the next request.
                        r_result       <= '0;
                        r_result_err   <= 1'b1;
                        r_result_valid <= 1'b1;
                        r_state        <= S_DRAIN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_DRAIN: begin
                    if (rvalid) begin
                        r_rready     <= 1'b0;
                        r_read_ready <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end

                default: begin
                    r_arvalid    <= 1'b0;
                    r_rready     <= 1'b0;
                    r_read_ready <= 1'b1;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign read_ready   = r_read_ready;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign result_err   = r_result_err;
    assign araddr       = r_araddr;
    assign arvalid      = r_arvalid;
    assign rready       = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_axil_times_table_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axil_times_table_reader
//  Description : Directed + randomized bench for axil_times_table_reader.
//                The bench plays the AXI4-Lite table slave and predicts
//                address, product and error status from plain arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_times_table_reader;

    localparam int          A_W     = 3;
    localparam int          B_W     = 3;
    localparam int          RES_W   = 6;
    localparam int          ADDR_W  = 32;
    localparam int          DATA_W  = 32;
    localparam logic [31:0] BASE    = 32'h0;
    localparam int          TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [A_W-1:0]    a;
    logic [B_W-1:0]    b;
    logic              read;
    logic              read_ready;
    logic [RES_W-1:0]  result;
    logic              result_valid;
    logic              result_err;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    int tests = 0;
    int fails = 0;
    logic [RES_W-1:0] last_result = '0;
    logic             last_err    = 1'b0;

    axil_times_table_reader #(
        .A_W(A_W), .B_W(B_W), .RES_W(RES_W), .ADDR_W(ADDR_W),
        .DATA_W(DATA_W), .BASE_ADDR(BASE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .read(read),
        .read_ready(read_ready), .result(result), .result_valid(result_valid),
        .result_err(result_err), .araddr(araddr), .arvalid(arvalid),
        .arready(arready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
        .rready(rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: table word address and product.
    function automatic logic [31:0] exp_addr(input int av, input int bv);
        return BASE + 32'((av * (1 << B_W) + bv) * 4);
    endfunction

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_arvalid"}, arvalid, 0);
        chk({tag, "_rready"}, rready, 0);
        chk({tag, "_rvalid_out"}, result_valid, 0);
        chk({tag, "_err"}, result_err, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_araddr"}, araddr, 0);
        chk({tag, "_read_ready"}, read_ready, 1);
    endtask

    // Request a lookup at a negedge and complete the AR handshake after
    // ard stall cycles. Returns at the first DATA-state negedge.
    task automatic issue(input int av, input int bv, input int ard);
        logic [31:0] ea;
        ea = exp_addr(av, bv);
        chk("read_ready_idle", read_ready, 1);
        a = A_W'(av); b = B_W'(bv); read = 1'b1; arready = 1'b0; rvalid = 1'b0;
        @(negedge clk);
        // Keep requesting with other operands: must be ignored while busy.
        a = A_W'($urandom); b = B_W'($urandom);
        chk("arvalid_set", arvalid, 1);
        chk("araddr", araddr, ea);
        chk("read_ready_busy", read_ready, 0);
        for (int i = 0; i < ard; i++) begin
            @(negedge clk);
            chk("arvalid_hold", arvalid, 1);
            chk("araddr_hold", araddr, ea);
        end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        chk("arvalid_drop", arvalid, 0);
        chk("rready_set", rready, 1);
    endtask

    task automatic lookup(input int av, input int bv, input int ard, input int rd,
                          input logic [1:0] resp, input logic [31:0] data);
        logic [RES_W-1:0] er;
        logic             ee;
        ee = (resp != 2'b00);
        er = ee ? '0 : RES_W'(av * bv);
        issue(av, bv, ard);
        for (int i = 0; i < rd; i++) begin
            chk("no_early_valid", result_valid, 0);
            chk("result_held", result, last_result);
            @(negedge clk);
        end
        rvalid = 1'b1; rdata = data; rresp = resp;
        @(negedge clk);
        rvalid = 1'b0; rresp = 2'b00; read = 1'b0;
        chk("result_valid", result_valid, 1);
        chk("result", result, er);
        chk("result_err", result_err, ee);
        chk("rready_drop", rready, 0);
        last_result = er; last_err = ee;
        @(negedge clk);
        chk("valid_pulse_end", result_valid, 0);
        chk("result_keep", result, er);
        chk("busy_read_ignored", arvalid, 0);
        chk("read_ready_back", read_ready, 1);
    endtask

    initial begin
        // ---- reset with random inputs ----
        rst = 1'b0; read = 1'b0; arready = 1'b0; rvalid = 1'b0;
        rdata = '0; rresp = 2'b00; a = '0; b = '0;
        for (int i = 0; i < 4; i++) begin
            a = A_W'($urandom); b = B_W'($urandom); read = 1'($urandom);
            arready = 1'($urandom); rvalid = 1'($urandom);
            rdata = $urandom; rresp = 2'($urandom);
            @(negedge clk);
            chk_idle_zero("reset");
        end
        rst = 1'b1; read = 1'b0;
        for (int i = 0; i < 3; i++) begin
            arready = 1'($urandom); rvalid = 1'($urandom); rdata = $urandom;
            @(negedge clk);
            chk_idle_zero("post_reset");
        end
        arready = 1'b0; rvalid = 1'b0;

        // ---- basic zero-wait lookup ----
        lookup(3, 5, 0, 0, 2'b00, 32'd15);
        chk("basic_addr_value", araddr, 32'h74);

        // ---- AR backpressure ----
        lookup(3, 5, 4, 0, 2'b00, 32'hABCD_0000 | 32'd15);

        // ---- slave error ----
        lookup(3, 5, 0, 1, 2'b10, 32'h2A);

        // ---- beat in the last allowed DATA cycle is a normal response ----
        lookup(6, 5, 1, TIMEOUT - 1, 2'b00, 32'h0000_0040 | 32'd30);

        // ---- timeout and drain ----
        issue(2, 7, 0);
        read = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            chk("timeout_wait", result_valid, 0);
            @(negedge clk);
        end
        chk("timeout_valid", result_valid, 1);
        chk("timeout_err", result_err, 1);
        chk("timeout_result", result, 0);
        chk("timeout_rready", rready, 1);
        read = 1'b1; a = 3'd1; b = 3'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("drain_no_pulse", result_valid, 0);
            chk("drain_rready", rready, 1);
            chk("drain_no_ar", arvalid, 0);
            chk("drain_busy", read_ready, 0);
        end
        rvalid = 1'b1; rdata = 32'd14; rresp = 2'b00;
        @(negedge clk);
        rvalid = 1'b0; read = 1'b0;
        chk("drain_end_no_pulse", result_valid, 0);
        chk("drain_end_rready", rready, 0);
        chk("drain_end_ready", read_ready, 1);
        chk("drain_result_kept", result, 0);
        chk("drain_err_kept", result_err, 1);
        @(negedge clk);
        chk("drain_read_ignored", arvalid, 0);
        last_result = '0;

        // ---- reset while waiting in DATA ----
        issue(2, 6, 0);
        read = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_rready", rready, 0);
        chk("async_rst_arvalid", arvalid, 0);
        chk("async_rst_result_valid", result_valid, 0);
        chk("async_rst_ready", read_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        last_result = '0;

        // ---- reset during the result pulse ----
        issue(1, 4, 0);
        read = 1'b0;
        rvalid = 1'b1; rdata = 32'd4;
        @(negedge clk);
        rvalid = 1'b0;
        chk("pulse_before_rst", result_valid, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_pulse", result_valid, 0);
        chk("async_rst_result", result, 0);
        @(negedge clk);
        rst = 1'b1;
        last_result = '0;

        lookup(7, 7, 0, 0, 2'b00, 32'd49);

        // ---- randomized sweep of all operand pairs ----
        for (int av = 0; av < 8; av++) begin
            for (int bv = 0; bv < 8; bv++) begin
                logic [1:0]  resp;
                logic [31:0] data;
                resp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                data = ($urandom & 32'hFFFF_FFC0) | 32'(av * bv);
                lookup(av, bv, $urandom_range(0, 3), $urandom_range(0, TIMEOUT - 1),
                       resp, data);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
